dcache_ufp_responder: RTL and testbench
=======================================

# dcache_ufp_responder

Direct-mapped, write-back, write-allocate data cache that serves the LSQ arbiter's `dcache_ufp_*` request port and fetches and evicts 256-bit lines over the `dfp_*` memory port. It is the responder end of the load/store path. It latches each single-cycle request, resolves it as a hit or miss, and returns exactly one `ufp_resp` pulse per request. Line storage is flop-based, with one valid bit and one dirty bit per set.

## Interface
Parameters:
- `SETS`, default 16: number of lines; must be a power of two ≥ 2. Index width is IW = log2(SETS); tag width is 27−IW.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ufp_addr` in 32: byte address, sampled when a mask is nonzero in IDLE.
- `ufp_rmask` in 4: byte read mask.
- `ufp_wmask` in 4: byte write mask.
- `ufp_wdata` in 32: store data, byte-lane aligned.
- `ufp_rdata` out 32: full aligned word; valid only with `ufp_resp`.
- `ufp_resp` out 1: one-cycle completion pulse.
- `dfp_addr` out 32: line address, bits [4:0] always 0.
- `dfp_read` out 1: line fill request, held until `dfp_resp`.
- `dfp_write` out 1: line writeback request, held until `dfp_resp`.
- `dfp_wdata` out 256: victim line data.
- `dfp_rdata` in 256: fill line data.
- `dfp_resp` in 1: memory completion pulse.
- `hit_count`, `miss_count`, `wb_count` out 32 each: performance counters (see Configuration).

## Operation
- Address split: offset = [4:0], word select = [4:2], index = [4+IW:5], tag = [31:5+IW].
- **IDLE**
  - If `|ufp_rmask | |ufp_wmask`, latch addr, masks and wdata, then go to TAG.
  - Other input values are ignored.
  - The requester holds masks for one cycle only and never issues while a request is outstanding.
- **TAG**: compare the latched tag with the stored tag of the indexed set, with valid=1.
  - Hit, read: `ufp_rdata` = stored word; `ufp_resp`=1; go to IDLE.
  - Hit, write: merge the `wmask` bytes into the word at the edge; set dirty; `ufp_resp`=1; `ufp_rdata`=0; go to IDLE.
  - If both masks are nonzero, it is treated as a write.
  - Miss with the victim valid and dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- **WRITEBACK**
  - `dfp_write`=1, `dfp_addr`={victim tag, index, 5'b0}, `dfp_wdata`=victim line.
  - On `dfp_resp`: clear dirty, go to ALLOCATE.
- **ALLOCATE**
  - `dfp_read`=1, `dfp_addr`={latched tag, index, 5'b0}.
  - On `dfp_resp`: write `dfp_rdata` into the line, set tag, valid=1, dirty=0; go to TAG, which then hits.
- `dfp_resp` outside WRITEBACK/ALLOCATE is ignored.
- `dfp_read` and `dfp_write` are never both 1.
- Pipeline flush is not an input: an in-flight request always completes.

## Timing
- Reset values: state=IDLE; all valid and dirty bits=0; `ufp_resp`=0, `ufp_rdata`=0, `dfp_read`=0, `dfp_write`=0, `dfp_addr`=0, `dfp_wdata`=0; counters=0. Data and tag arrays are not reset.
- Hit: request at cycle 0, `ufp_resp` at cycle 1.
- Clean miss:
  - `dfp_read` is asserted from cycle 2 until the `dfp_resp` cycle F.
  - `ufp_resp` is at F+1, i.e. memory latency + 2.
- Dirty miss: adds the writeback handshake before the fill; `dfp_read` rises the cycle after the writeback `dfp_resp`.
- Outputs are registered-state decoded. No combinational path exists from `ufp_*` to `ufp_resp`.
- The earliest next request is accepted the cycle after `ufp_resp`.
- Reset mid-miss: `dfp_read`/`dfp_write` drop asynchronously. A late `dfp_resp` after reset is ignored, and the line stays invalid.

## Configuration
- `DCACHE_PERF_EN` defined:
  - `hit_count` increments on each TAG hit that is not the retry after a fill.
  - `miss_count` increments on each TAG→WRITEBACK or TAG→ALLOCATE transition.
  - `wb_count` increments on each writeback `dfp_resp`.
  - All three wrap at 2^32.
- `DCACHE_PERF_EN` undefined: the ports remain and are tied to 0. No counter flops are built.

## Test plan
- **Reset, cold read**: reset, then read rmask=4'hF at 0x0000_1004 with memory line = word i → value 0x1000+i. Expect `dfp_read` with `dfp_addr`=0x0000_1000, then `ufp_rdata`=0x1001 one cycle after `dfp_resp`; `miss_count`=1.
- **Write hit, merge**: after the cold read, write wmask=4'b0110, wdata=0xAABBCCDD to 0x1004, then read 0x1004. Expect the write `ufp_resp` at +1 cycle with no dfp activity; the read returns 0x00BBCC01 (bytes 1–2 replaced in 0x00001001); `hit_count`=2.
- **Dirty eviction**: with SETS=16, read 0x0000_1204 (same index, new tag). Expect `dfp_write` at 0x1000 carrying the modified line first, then `dfp_read` at 0x1200; `wb_count`=1.
- **Clean eviction**: repeat an eviction on the now-clean set. Expect `dfp_read` only, with `dfp_write` never asserted.
- **Reset mid-fill**: assert `rst_n`=0 while `dfp_read`=1, then pulse `dfp_resp` after release. Expect no state change; the next read to the same address misses again.
- **Back-to-back**: issue a new request in the cycle after each `ufp_resp` for 8 hits. Expect exactly 8 responses, each 1 cycle after its request.

Source files
------------

// File: rtl/dcache_ufp_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ufp_responder_if
//  Purpose  : Bundles the LSQ-side request port (ufp_*) and the memory-side
//             line port (dfp_*) of the data cache.
//  Modports : slave  - the cache (responds on ufp_*, requests on dfp_*)
//             master - the environment (LSQ arbiter + memory)
//  Signals  : ufp_addr/rmask/wmask/wdata -> cache, ufp_rdata/resp <- cache
//             dfp_addr/read/write/wdata  <- cache, dfp_rdata/resp -> cache
//  Revision : 1.0 - initial release
// ============================================================================
interface dcache_ufp_responder_if;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;

  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  modport slave (
    input  ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
    output ufp_rdata, ufp_resp,
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  modport master (
    output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
    input  ufp_rdata, ufp_resp,
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface
`default_nettype wire

// File: rtl/dcache_ufp_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ufp_responder
//  Purpose  : Direct-mapped, write-back, write-allocate data cache with
//             flop-based 256-bit lines. Latches single-cycle LSQ requests,
//             resolves hit/miss, evicts dirty victims and fills over dfp_*.
//  Ports    : clk, rst_n (async, active-low)
//             bus        - dcache_ufp_responder_if.slave (ufp_* / dfp_*)
//             hit_count, miss_count, wb_count - performance counters
//  Config   : SETS (power of two >= 2)
//             DCACHE_PERF_EN - when defined, builds the three counters;
//             otherwise the counter ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_ufp_responder #(
  parameter int SETS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_ufp_responder_if.slave bus,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 27 - IW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TAG       = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_e;

  state_e          state_q;
  logic [31:2]     addr_q;
  logic [3:0]      wmask_q;
  logic [31:0]     wdata_q;
  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [255:0]    data_q [SETS];
  logic [TW-1:0]   tag_q  [SETS];

  logic [IW-1:0]   w_idx;
  logic [TW-1:0]   w_tag;
  logic [TW-1:0]   w_vtag;
  logic [255:0]    w_line;
  logic [7:0]      w_bit_off;
  logic [31:0]     w_word_data;
  logic [31:0]     w_merged;
  logic [255:0]    w_line_merged;
  logic            w_hit;
  logic            w_is_wr;
  logic            w_victim_dirty;
  logic            w_unused;

  // Byte offset is irrelevant: the full aligned word is always returned.
  assign w_unused       = ^bus.ufp_addr[1:0];

  assign w_idx          = addr_q[4+IW:5];
  assign w_tag          = addr_q[31:5+IW];
  assign w_bit_off      = {addr_q[4:2], 5'b0};
  assign w_line         = data_q[w_idx];
  assign w_vtag         = tag_q[w_idx];
  assign w_word_data    = w_line[w_bit_off +: 32];
  assign w_hit          = valid_q[w_idx] && (w_vtag == w_tag);
  // Any nonzero write mask makes the access a store, even if rmask is set.
  assign w_is_wr        = |wmask_q;
  assign w_victim_dirty = valid_q[w_idx] && dirty_q[w_idx];

  always_comb begin
    w_merged = w_word_data;
    for (int b = 0; b < 4; b++) begin
      if (wmask_q[b]) w_merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
    w_line_merged = w_line;
    w_line_merged[w_bit_off +: 32] = w_merged;
  end

  // Outputs decode only registered state, so reset drops them asynchronously
  // and nothing on ufp_* reaches ufp_resp combinationally.
  always_comb begin
    bus.ufp_resp  = (state_q == S_TAG) && w_hit;
    bus.ufp_rdata = ((state_q == S_TAG) && w_hit && !w_is_wr) ? w_word_data : 32'h0;
    bus.dfp_read  = (state_q == S_ALLOCATE);
    bus.dfp_write = (state_q == S_WRITEBACK);
    bus.dfp_addr  = 32'h0;
    bus.dfp_wdata = '0;
    if (state_q == S_WRITEBACK) begin
      bus.dfp_addr  = {w_vtag, w_idx, 5'b0};
      bus.dfp_wdata = w_line;
    end else if (state_q == S_ALLOCATE) begin
      bus.dfp_addr  = {w_tag, w_idx, 5'b0};
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;
  logic [31:0] wb_count_q;
  logic        fill_retry_q;  // next TAG visit is the post-fill retry
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
`ifdef DCACHE_PERF_EN
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
      fill_retry_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((|bus.ufp_rmask) || (|bus.ufp_wmask)) begin
            addr_q  <= bus.ufp_addr[31:2];
            wmask_q <= bus.ufp_wmask;
            wdata_q <= bus.ufp_wdata;
            state_q <= S_TAG;
          end
        end
        S_TAG: begin
          if (w_hit) begin
            if (w_is_wr) dirty_q[w_idx] <= 1'b1;
            state_q <= S_IDLE;
`ifdef DCACHE_PERF_EN
            if (!fill_retry_q) hit_count_q <= hit_count_q + 32'd1;
            fill_retry_q <= 1'b0;
`endif
          end else begin
            state_q <= w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
`ifdef DCACHE_PERF_EN
            miss_count_q <= miss_count_q + 32'd1;
`endif
          end
        end
        S_WRITEBACK: begin
          if (bus.dfp_resp) begin
            dirty_q[w_idx] <= 1'b0;
            state_q        <= S_ALLOCATE;
`ifdef DCACHE_PERF_EN
            wb_count_q <= wb_count_q + 32'd1;
`endif
          end
        end
        S_ALLOCATE: begin
          if (bus.dfp_resp) begin
            valid_q[w_idx] <= 1'b1;
            dirty_q[w_idx] <= 1'b0;
            state_q        <= S_TAG;
`ifdef DCACHE_PERF_EN
            fill_retry_q <= 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid bits guard its contents.
  always_ff @(posedge clk) begin
    if ((state_q == S_ALLOCATE) && bus.dfp_resp) begin
      data_q[w_idx] <= bus.dfp_rdata;
      tag_q[w_idx]  <= w_tag;
    end else if ((state_q == S_TAG) && w_hit && w_is_wr) begin
      data_q[w_idx] <= w_line_merged;
    end
  end

`ifdef DCACHE_PERF_EN
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
  assign wb_count   = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ufp_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ufp_responder
//  Purpose  : Self-checking bench for dcache_ufp_responder. A flat golden
//             memory image gives expected load data; a per-set residency
//             model predicts hit/miss/writeback and handshake timing; a
//             randomized-latency memory responder serves dfp_*.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ufp_responder;
  localparam int SETS = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hit_count, miss_count, wb_count;

  always #5 clk = ~clk;

  dcache_ufp_responder_if bus ();

  dcache_ufp_responder #(.SETS(SETS)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Golden program-order image (word address -> word) and backing memory.
  logic [31:0]  gold [logic [31:0]];
  logic [255:0] mem  [logic [31:0]];

  // Residency model: which line each set holds and whether it is modified.
  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  bit          m_dirty [SETS];
  int          m_hits, m_misses, m_wbs;

  // Memory-side observation.
  bit           mem_auto = 1'b1;
  int           lat_left = -1;
  int           first_rd_cyc, first_wr_cyc, fill_resp_cyc, wb_resp_cyc;
  int           resp_cnt = 0;
  int           both_cnt = 0;
  bit           prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0]  wb_addr_q [$];
  logic [255:0] wb_data_q [$];
  logic [31:0]  fill_addr_q [$];

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Power-on memory contents: word i of a line holds line_base + i.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a & ~32'h1f) + ((a >> 2) & 32'h7);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'h3;
    return gold.exists(wa) ? gold[wa] : init_word(wa);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_rd(base + 32'(4*w));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] base);
    logic [255:0] l;
    if (mem.exists(base)) return mem[base];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(base + 32'(4*w));
    return l;
  endfunction

  // Memory responder and bus monitor.
  initial begin
    bus.dfp_resp  = 1'b0;
    bus.dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.dfp_read && bus.dfp_write) both_cnt++;
      if (bus.dfp_read && !prev_rd)  first_rd_cyc = cyc;
      if (bus.dfp_write && !prev_wr) first_wr_cyc = cyc;
      prev_rd = bus.dfp_read;
      prev_wr = bus.dfp_write;
      if (bus.ufp_resp) resp_cnt++;
      if (mem_auto) begin
        if (bus.dfp_resp) begin
          bus.dfp_resp = 1'b0;
          lat_left     = -1;
        end else if (bus.dfp_read || bus.dfp_write) begin
          if (lat_left < 0) lat_left = int'($urandom_range(0, 3));
          if (lat_left == 0) begin
            if (bus.dfp_write) begin
              mem[bus.dfp_addr] = bus.dfp_wdata;
              wb_addr_q.push_back(bus.dfp_addr);
              wb_data_q.push_back(bus.dfp_wdata);
              wb_resp_cyc = cyc;
            end else begin
              bus.dfp_rdata = mem_line(bus.dfp_addr);
              fill_addr_q.push_back(bus.dfp_addr);
              fill_resp_cyc = cyc;
            end
            bus.dfp_resp = 1'b1;
          end else begin
            lat_left--;
          end
        end
      end
    end
  end

  task automatic chk_counters(input string tag);
`ifdef DCACHE_PERF_EN
    chk_eq({tag, "_hit_count"},  hit_count,  32'(m_hits));
    chk_eq({tag, "_miss_count"}, miss_count, 32'(m_misses));
    chk_eq({tag, "_wb_count"},   wb_count,   32'(m_wbs));
`else
    chk_eq({tag, "_hit_count"},  hit_count,  32'h0);
    chk_eq({tag, "_miss_count"}, miss_count, 32'h0);
    chk_eq({tag, "_wb_count"},   wb_count,   32'h0);
`endif
  endtask

  // Reset discards modified lines: the golden image falls back to memory.
  task automatic model_reset();
    logic [31:0]  base;
    logic [255:0] l;
    for (int s = 0; s < SETS; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        base = m_tag[s] * 32'(SETS * 32) + 32'(s * 32);
        l    = mem_line(base);
        for (int w = 0; w < 8; w++) gold[base + 32'(4*w)] = l[32*w +: 32];
      end
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd);
    int          set, c0, n;
    logic [31:0] tg, old_base, new_base, exp_rd, w;
    bit          hit, wb;
    set      = int'((a >> 5) & 32'(SETS - 1));
    tg       = a / 32'(SETS * 32);
    hit      = m_valid[set] && (m_tag[set] == tg);
    wb       = !hit && m_valid[set] && m_dirty[set];
    old_base = m_tag[set] * 32'(SETS * 32) + 32'(set * 32);
    new_base = a & ~32'h1f;
    exp_rd   = (wm != 4'h0) ? 32'h0 : gold_rd(a);
    wb_addr_q.delete(); wb_data_q.delete(); fill_addr_q.delete();
    first_rd_cyc = -1; first_wr_cyc = -1;

    @(negedge clk);
    c0 = cyc;
    bus.ufp_addr  = a;
    bus.ufp_rmask = rm;
    bus.ufp_wmask = wm;
    bus.ufp_wdata = wd;
    @(negedge clk);
    bus.ufp_rmask = 4'h0;
    bus.ufp_wmask = 4'h0;
    n = 1;
    while (!bus.ufp_resp && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk_eq("ufp_resp", bus.ufp_resp, 1'b1);
    chk_eq("ufp_rdata", bus.ufp_rdata, exp_rd);
    if (hit) begin
      chk_eq("hit_latency", cyc - c0, 1);
      chk_eq("hit_no_dfp", wb_addr_q.size() + fill_addr_q.size(), 0);
      m_hits++;
    end else begin
      chk_eq("fill_count", fill_addr_q.size(), 1);
      if (fill_addr_q.size() == 1) chk_eq("fill_addr", fill_addr_q[0], new_base);
      chk_eq("miss_resp_cycle", cyc, fill_resp_cyc + 1);
      if (wb) begin
        chk_eq("wb_count_bus", wb_addr_q.size(), 1);
        if (wb_addr_q.size() == 1) begin
          chk_eq("wb_addr", wb_addr_q[0], old_base);
          chk_eq("wb_data", wb_data_q[0], gold_line(old_base));
        end
        chk_eq("wb_start", first_wr_cyc, c0 + 2);
        chk_eq("fill_after_wb", first_rd_cyc, wb_resp_cyc + 1);
        m_wbs++;
      end else begin
        chk_eq("no_wb", wb_addr_q.size(), 0);
        chk_eq("fill_start", first_rd_cyc, c0 + 2);
      end
      m_misses++;
      m_valid[set] = 1'b1;
      m_tag[set]   = tg;
      m_dirty[set] = 1'b0;
    end
    if (wm != 4'h0) begin
      w = gold_rd(a);
      for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
      gold[a & ~32'h3] = w;
      m_dirty[set] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, r0, kind;
    logic [31:0] a, wd;
    logic [3:0]  rm, wm;

    bus.ufp_addr = '0; bus.ufp_rmask = '0; bus.ufp_wmask = '0; bus.ufp_wdata = '0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    chk_eq("rst_ufp_resp",  bus.ufp_resp,  1'b0);
    chk_eq("rst_ufp_rdata", bus.ufp_rdata, 32'h0);
    chk_eq("rst_dfp_read",  bus.dfp_read,  1'b0);
    chk_eq("rst_dfp_write", bus.dfp_write, 1'b0);
    chk_eq("rst_dfp_addr",  bus.dfp_addr,  32'h0);
    chk_eq("rst_dfp_wdata", bus.dfp_wdata, 256'h0);
    chk_counters("rst");
    rst_n = 1'b1;

    // Cold read, write-hit merge, dirty eviction, clean eviction.
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0);
    chk_counters("cold");
    do_req(32'h0000_1004, 4'h0, 4'b0110, 32'hAABB_CCDD);
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0);
    chk_eq("merge_value", gold_rd(32'h1004), 32'h00BB_CC01);
    chk_counters("merge");
    do_req(32'h0000_1204, 4'hF, 4'h0, 32'h0);
    chk_counters("dirty_evict");
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0);
    chk_counters("clean_evict");

    // Reset in the middle of a fill; a late dfp_resp must be ignored.
    mem_auto = 1'b0;
    @(negedge clk);
    bus.ufp_addr = 32'h0000_1404; bus.ufp_rmask = 4'hF;
    @(negedge clk);
    bus.ufp_rmask = 4'h0;
    n = 0;
    while (!bus.dfp_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("rf_read_up", bus.dfp_read, 1'b1);
    chk_eq("rf_addr", bus.dfp_addr, 32'h0000_1400);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rf_read_async_drop", bus.dfp_read, 1'b0);
    chk_eq("rf_write_low", bus.dfp_write, 1'b0);
    model_reset();
    r0 = resp_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dfp_rdata = {8{32'hDEAD_BEEF}};
    bus.dfp_resp  = 1'b1;
    @(negedge clk);
    bus.dfp_resp  = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rf_no_resp", resp_cnt - r0, 0);
    chk_eq("rf_idle_read", bus.dfp_read, 1'b0);
    chk_counters("rf");
    mem_auto = 1'b1;
    do_req(32'h0000_1404, 4'hF, 4'h0, 32'h0);

    // Back-to-back hits within one resident line.
    r0 = resp_cnt;
    for (int i = 0; i < 8; i++) begin
      a = 32'h0000_1400 + 32'(4 * i);
      if (i % 2 == 0) do_req(a, 4'h0, 4'hF, $urandom);
      else            do_req(a, 4'hF, 4'h0, 32'h0);
    end
    @(negedge clk);
    chk_eq("b2b_resp_count", resp_cnt - r0, 8);

    // Randomized traffic over four conflicting tags per set.
    for (int i = 0; i < 200; i++) begin
      a = 32'h0001_0000 | ($urandom_range(0, 3) << 9)
        | ($urandom_range(0, SETS - 1) << 5) | ($urandom_range(0, 7) << 2);
      kind = int'($urandom_range(0, 2));
      rm = 4'h0; wm = 4'h0;
      if (kind != 1) rm = 4'($urandom_range(1, 15));
      if (kind != 0) wm = 4'($urandom_range(1, 15));
      wd = $urandom;
      do_req(a, rm, wm, wd);
    end
    @(negedge clk);
    chk_counters("final");
    chk_eq("read_write_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
